// File: rtl/mem_access_wb_stage_pkg.sv
// Shared encodings for the M-stage memory access and M/W pipeline register.
package mem_access_wb_stage_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Size code 3 aliases to word, so anything not byte/half needs word alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      default: is_misaligned = |a;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_wb_stage_load_align_ext.sv
// Combinational load-data lane select and sign/zero extension.
module load_align_ext
  import mem_access_wb_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_wb_stage.sv
// M-stage data-memory access (ready handshake with timeout) and M/W pipeline register.
module mem_access_wb_stage
  import mem_access_wb_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [4:0]  WriteRegM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [4:0]  WriteRegW,
  output logic        AlignErrW,
  output logic        BusErrW
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      r_state, w_state_nx;
  logic [7:0]  r_wcnt, w_wcnt_nx;
  logic        w_mem_op, w_is_load, w_misalign, w_issue, w_timeout;
  logic [31:0] w_ext;

  always_comb begin
    w_mem_op   = MemReadM | MemWriteM;
    w_is_load  = MemReadM & ~MemWriteM;
    w_misalign = w_mem_op & is_misaligned(MemSizeM, ALUOutM[1:0]);
    w_issue    = w_mem_op & ~w_misalign;
    // Gated by rst_n so the bus sees no request while reset is held.
    dmem_req   = rst_n & ((r_state == S_WAIT) | w_issue);
    w_timeout  = (r_state == S_WAIT) & ~dmem_ready & (r_wcnt == TIMEOUT_CNT);
    StallM     = dmem_req & ~dmem_ready & ~w_timeout;
    dmem_addr  = {ALUOutM[31:2], 2'b00};
  end

  always_comb begin
    dmem_we    = 1'b0;
    dmem_be    = '0;
    dmem_wdata = '0;
    if (dmem_req) begin
      dmem_we = MemWriteM;
      case (MemSizeM)
        SZ_BYTE: begin
          dmem_be    = 4'b0001 << ALUOutM[1:0];
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        SZ_HALF: begin
          dmem_be    = 4'b0011 << {ALUOutM[1], 1'b0};
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = WriteDataM;
        end
      endcase
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_wcnt_nx  = r_wcnt;
    case (r_state)
      S_IDLE: begin
        if (dmem_req & ~dmem_ready) begin
          w_state_nx = S_WAIT;
          w_wcnt_nx  = 8'd1;
        end
      end
      S_WAIT: begin
        if (dmem_ready | w_timeout) begin
          w_state_nx = S_IDLE;
          w_wcnt_nx  = '0;
        end else begin
          w_wcnt_nx  = r_wcnt + 8'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_wcnt_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_wcnt  <= w_wcnt_nx;
    end
  end

  load_align_ext u_load_align_ext (
    .i_rdata  (dmem_rdata),
    .i_addr   (ALUOutM[1:0]),
    .i_size   (MemSizeM),
    .i_signed (MemSignedM),
    .o_data   (w_ext)
  );

  // While stalled the W stage takes a bubble; data fields keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WriteRegW <= '0;
      AlignErrW <= 1'b0;
      BusErrW   <= 1'b0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      AlignErrW <= 1'b0;
      BusErrW   <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM & ~w_misalign & ~w_timeout;
      MemtoRegW <= MemtoRegM;
      ReadDataW <= (w_is_load & dmem_req & dmem_ready) ? w_ext : '0;
      ALUOutW   <= ALUOutM;
      WriteRegW <= WriteRegM;
      AlignErrW <= w_misalign;
      BusErrW   <= w_timeout;
    end
  end

endmodule

// File: tb/tb_mem_access_wb_stage.sv
// Self-checking bench: fixed vector table, random ops against a reference model, corner sequences.
module tb_mem_access_wb_stage;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM, MemtoRegM, MemReadM, MemWriteM, MemSignedM;
  logic [1:0]  MemSizeM;
  logic [31:0] ALUOutM, WriteDataM, dmem_rdata;
  logic [4:0]  WriteRegM;
  logic        dmem_req, dmem_we, dmem_ready, StallM;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        RegWriteW, MemtoRegW, AlignErrW, BusErrW;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cur = 0;

  always #5 clk = ~clk;

  mem_access_wb_stage #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .MemSizeM(MemSizeM), .MemSignedM(MemSignedM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .StallM(StallM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WriteRegW(WriteRegW), .AlignErrW(AlignErrW), .BusErrW(BusErrW)
  );

  typedef struct {
    logic        rw, m2r, rd, wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr, wd, rdata;
    logic [4:0]  wreg;
  } op_t;

  typedef struct {
    op_t         o;
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_rw, e_m2r;
    logic [31:0] e_rdw;
    logic        e_aerr;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s op=%0d actual=%h expected=%h", nm, cur, act, exp);
    end
  endtask

  task automatic drive(input op_t o);
    RegWriteM = o.rw; MemtoRegM = o.m2r; MemReadM = o.rd; MemWriteM = o.wr;
    MemSizeM = o.sz; MemSignedM = o.sg; ALUOutM = o.addr; WriteDataM = o.wd;
    WriteRegM = o.wreg; dmem_rdata = o.rdata;
  endtask

  // Reference model, written from the access rules with plain arithmetic.
  function automatic logic m_mis(input op_t o);
    if (!(o.rd || o.wr)) return 1'b0;
    if (o.sz == 2'd0) return 1'b0;
    if (o.sz == 2'd1) return (o.addr % 2) != 0;
    return (o.addr % 4) != 0;
  endfunction

  function automatic logic [31:0] m_load(input op_t o);
    logic [31:0] v;
    int unsigned lane;
    if (o.sz == 2'd0) begin
      lane = o.addr % 4;
      v = (o.rdata >> (8 * lane)) & 32'hFF;
      if (o.sg && v >= 32'd128) v = v - 32'd256;
    end else if (o.sz == 2'd1) begin
      lane = (o.addr % 4) / 2;
      v = (o.rdata >> (16 * lane)) & 32'hFFFF;
      if (o.sg && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = o.rdata;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input op_t o);
    if (o.sz == 2'd0) return 4'(1 << (o.addr % 4));
    if (o.sz == 2'd1) return ((o.addr % 4) >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_wdata(input op_t o);
    if (o.sz == 2'd0) return (o.wd & 32'hFF) * 32'h01010101;
    if (o.sz == 2'd1) return (o.wd & 32'hFFFF) * 32'h00010001;
    return o.wd;
  endfunction

  // Applies one op whose data arrives after `lat` wait cycles; checks every cycle.
  task automatic run_op(input op_t o, input int unsigned lat, output int unsigned nstall);
    logic mis, aligned, ok, ld;
    int unsigned s;
    mis     = m_mis(o);
    aligned = (o.rd || o.wr) && !mis;
    ok      = aligned && (lat <= T);
    ld      = o.rd && !o.wr;
    s       = !aligned ? 0 : ((lat <= T) ? lat : T);
    nstall  = 0;
    @(negedge clk);
    drive(o);
    for (int unsigned k = 0; k <= s; k++) begin
      dmem_ready = aligned ? (k == lat) : 1'($urandom_range(0, 1));
      #1;
      if (StallM) nstall++;
      chk("dmem_req", 32'(dmem_req), 32'(aligned));
      chk("StallM", 32'(StallM), 32'(k < s));
      if (aligned) begin
        chk("dmem_addr", dmem_addr, o.addr & 32'hFFFFFFFC);
        chk("dmem_we", 32'(dmem_we), 32'(o.wr));
        if (o.wr) begin
          chk("dmem_be", 32'(dmem_be), 32'(m_be(o)));
          chk("dmem_wdata", dmem_wdata, m_wdata(o));
        end
      end else begin
        chk("dmem_we_idle", 32'(dmem_we), 32'd0);
        chk("dmem_be_idle", 32'(dmem_be), 32'd0);
      end
      @(posedge clk);
      #1;
      if (k < s) begin
        chk("bubble_RegWriteW", 32'(RegWriteW), 32'd0);
        chk("bubble_MemtoRegW", 32'(MemtoRegW), 32'd0);
      end
    end
    chk("RegWriteW", 32'(RegWriteW), 32'(o.rw && !mis && !(aligned && !ok)));
    chk("MemtoRegW", 32'(MemtoRegW), 32'(o.m2r));
    chk("ReadDataW", ReadDataW, (ld && ok) ? m_load(o) : 32'd0);
    chk("ALUOutW", ALUOutW, o.addr);
    chk("WriteRegW", 32'(WriteRegW), 32'(o.wreg));
    chk("AlignErrW", 32'(AlignErrW), 32'(mis));
    chk("BusErrW", 32'(BusErrW), 32'(aligned && !ok));
    dmem_ready = 1'b0;
  endtask

  function automatic op_t mk(input logic rw, m2r, rd, wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, wd, rdata, input logic [4:0] wreg);
    op_t o;
    o.rw = rw; o.m2r = m2r; o.rd = rd; o.wr = wr; o.sz = sz; o.sg = sg;
    o.addr = addr; o.wd = wd; o.rdata = rdata; o.wreg = wreg;
    return o;
  endfunction

  initial begin
    vec_t        vt[12];
    op_t         o, nop;
    int unsigned ns;

    nop = mk(0, 0, 0, 0, 2'd0, 0, 32'd0, 32'd0, 32'd0, 5'd0);
    //                 rw m2r rd wr sz  sg addr          wd            rdata         wreg   req we be       wdata         rw m2r rdw           aerr
    vt[0]  = '{mk(1, 1, 1, 0, 2'd2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 5'd5),  1, 0, 4'b0000, 32'h0,        1, 1, 32'hDEADBEEF, 0};
    vt[1]  = '{mk(0, 0, 0, 1, 2'd1, 0, 32'h102, 32'h1234ABCD, 32'h0,        5'd0),  1, 1, 4'b1100, 32'hABCDABCD, 0, 0, 32'h0,        0};
    vt[2]  = '{mk(1, 1, 1, 0, 2'd2, 0, 32'h101, 32'h0,        32'h11111111, 5'd7),  0, 0, 4'b0000, 32'h0,        0, 1, 32'h0,        1};
    vt[3]  = '{mk(1, 1, 1, 0, 2'd0, 1, 32'h103, 32'h0,        32'h80123456, 5'd3),  1, 0, 4'b0000, 32'h0,        1, 1, 32'hFFFFFF80, 0};
    vt[4]  = '{mk(1, 1, 1, 0, 2'd1, 0, 32'h102, 32'h0,        32'hBEEF1234, 5'd4),  1, 0, 4'b0000, 32'h0,        1, 1, 32'h0000BEEF, 0};
    vt[5]  = '{mk(0, 0, 0, 1, 2'd0, 0, 32'h001, 32'h0000005A, 32'h0,        5'd0),  1, 1, 4'b0010, 32'h5A5A5A5A, 0, 0, 32'h0,        0};
    vt[6]  = '{mk(1, 0, 0, 0, 2'd0, 0, 32'h12345678, 32'h0,   32'hFFFFFFFF, 5'd9),  0, 0, 4'b0000, 32'h0,        1, 0, 32'h0,        0};
    vt[7]  = '{mk(1, 1, 1, 0, 2'd1, 1, 32'h100, 32'h0,        32'h00008001, 5'd10), 1, 0, 4'b0000, 32'h0,        1, 1, 32'hFFFF8001, 0};
    vt[8]  = '{mk(1, 1, 1, 0, 2'd3, 0, 32'h200, 32'h0,        32'hCAFEF00D, 5'd11), 1, 0, 4'b0000, 32'h0,        1, 1, 32'hCAFEF00D, 0};
    vt[9]  = '{mk(0, 0, 0, 1, 2'd2, 0, 32'h206, 32'h55667788, 32'h0,        5'd0),  0, 0, 4'b0000, 32'h0,        0, 0, 32'h0,        1};
    vt[10] = '{mk(1, 0, 1, 1, 2'd0, 0, 32'h003, 32'h000000A5, 32'h12345678, 5'd12), 1, 1, 4'b1000, 32'hA5A5A5A5, 1, 0, 32'h0,        0};
    vt[11] = '{mk(1, 1, 1, 0, 2'd0, 0, 32'h101, 32'h0,        32'h0000FF00, 5'd13), 1, 0, 4'b0000, 32'h0,        1, 1, 32'h000000FF, 0};

    // Reset with an aligned load presented: no request or stall may escape.
    rst_n = 1'b0;
    dmem_ready = 1'b0;
    drive(mk(1, 1, 1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h0, 5'd1));
    #2;
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_StallM", 32'(StallM), 32'd0);
    chk("rst_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst_ReadDataW", ReadDataW, 32'd0);
    chk("rst_ALUOutW", ALUOutW, 32'd0);
    chk("rst_WriteRegW", 32'(WriteRegW), 32'd0);
    drive(nop);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table: zero-wait single-cycle vectors with hand-derived expectations.
    for (int i = 0; i < 12; i++) begin
      cur = 100 + i;
      @(negedge clk);
      drive(vt[i].o);
      dmem_ready = 1'b1;
      #1;
      chk("tv_dmem_req", 32'(dmem_req), 32'(vt[i].e_req));
      chk("tv_StallM", 32'(StallM), 32'd0);
      chk("tv_dmem_we", 32'(dmem_we), 32'(vt[i].e_we));
      if (vt[i].e_we) begin
        chk("tv_dmem_be", 32'(dmem_be), 32'(vt[i].e_be));
        chk("tv_dmem_wdata", dmem_wdata, vt[i].e_wdata);
      end
      @(posedge clk);
      #1;
      chk("tv_RegWriteW", 32'(RegWriteW), 32'(vt[i].e_rw));
      chk("tv_MemtoRegW", 32'(MemtoRegW), 32'(vt[i].e_m2r));
      chk("tv_ReadDataW", ReadDataW, vt[i].e_rdw);
      chk("tv_ALUOutW", ALUOutW, vt[i].o.addr);
      chk("tv_WriteRegW", 32'(WriteRegW), 32'(vt[i].o.wreg));
      chk("tv_AlignErrW", 32'(AlignErrW), 32'(vt[i].e_aerr));
      chk("tv_BusErrW", 32'(BusErrW), 32'd0);
    end
    dmem_ready = 1'b0;

    // Multi-cycle corner sequences.
    cur = 200;
    run_op(mk(1, 1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80ABCDEF, 5'd2), 3, ns);
    chk("lb_stalls", ns, 32'd3);
    chk("lb_value", ReadDataW, 32'hFFFFFF80);
    cur = 201;
    run_op(mk(1, 1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80ABCDEF, 5'd2), 3, ns);
    chk("lbu_stalls", ns, 32'd3);
    chk("lbu_value", ReadDataW, 32'h00000080);
    cur = 202;
    run_op(mk(1, 1, 1, 0, 2'd2, 0, 32'h500, 32'h0, 32'h13572468, 5'd6), 50, ns);
    chk("to_stalls", ns, 32'(T));
    chk("to_BusErrW", 32'(BusErrW), 32'd1);
    chk("to_RegWriteW", 32'(RegWriteW), 32'd0);
    cur = 203;
    run_op(mk(1, 1, 1, 0, 2'd2, 0, 32'h504, 32'h0, 32'h2468ACE0, 5'd6), T, ns);
    chk("edge_stalls", ns, 32'(T));
    chk("edge_BusErrW", 32'(BusErrW), 32'd0);
    chk("edge_value", ReadDataW, 32'h2468ACE0);

    // Reset while waiting abandons the access and clears W immediately.
    cur = 204;
    @(negedge clk);
    drive(mk(1, 1, 1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h0BADF00D, 5'd8));
    dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_dmem_req", 32'(dmem_req), 32'd0);
    chk("rstw_StallM", 32'(StallM), 32'd0);
    chk("rstw_RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rstw_MemtoRegW", 32'(MemtoRegW), 32'd0);
    chk("rstw_ReadDataW", ReadDataW, 32'd0);
    chk("rstw_ALUOutW", ALUOutW, 32'd0);
    chk("rstw_WriteRegW", 32'(WriteRegW), 32'd0);
    chk("rstw_BusErrW", 32'(BusErrW), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur = 205;
    run_op(mk(1, 1, 1, 0, 2'd2, 0, 32'h300, 32'h0, 32'h0BADF00D, 5'd8), 1, ns);
    chk("post_rst_stalls", ns, 32'd1);

    // Random ops with random wait latency (some beyond the timeout).
    for (int i = 0; i < 60; i++) begin
      cur = 300 + i;
      o = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
      run_op(o, $urandom_range(0, 6), ns);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog op=%0d actual=hung expected=finish", cur);
    $fatal(1);
  end

endmodule

// File: doc/mem_access_wb_stage.md
# mem_access_wb_stage

Memory-access stage plus M/W pipeline register of the pipelined MIPS core. Takes the M-stage instruction, performs its data-memory load or store over a ready-handshaked bus, aligns and extends load data, and registers the W-stage values (`ReadDataW`, `ALUOutW`, `MemtoRegW`, `RegWriteW`, `WriteRegW`) consumed by the write-back result mux. Stalls the upstream pipeline while an access is outstanding, and aborts accesses that time out.

## Interface
- `TIMEOUT`, 16: wait cycles after issue before an access is aborted; legal range 1..255.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `RegWriteM`, `MemtoRegM`, `MemReadM`, `MemWriteM`  in  1 each  M-stage control bits.
- `MemSizeM`  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `MemSignedM`  in  1  sign-extend loads when 1, zero-extend when 0.
- `ALUOutM`  in  32  effective address / ALU result.
- `WriteDataM`  in  32  store data, right-justified.
- `WriteRegM`  in  5  destination register.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word address: `{ALUOutM[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables, bit i = byte lane i, little-endian.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rdata`  in  32  load data, valid while `dmem_ready` is high.
- `dmem_ready`  in  1  access complete this cycle.
- `StallM`  out  1  hold the F/D/E/M stages this cycle.
- `RegWriteW`, `MemtoRegW`  out  1 each  registered W controls.
- `ReadDataW`, `ALUOutW`  out  32 each  registered load data and ALU result.
- `WriteRegW`  out  5  registered destination.
- `AlignErrW`, `BusErrW`  out  1 each  registered exception flags for the W instruction.

## Operation
- Memory op: `MemReadM | MemWriteM`. If both are set, the op is a store.
- Misalignment: half with `ALUOutM[0]=1`, or word with `ALUOutM[1:0]!=0`. No request is issued. The instruction completes in the same cycle with `AlignErrW=1`, `RegWriteW=0`, and `StallM=0`.
- FSM states: `IDLE` and `WAIT`. An 8-bit counter `wcnt` tracks wait cycles.
- `IDLE`, aligned memory op:
  - `dmem_req=1` combinationally.
  - If `dmem_ready=1` in the same cycle, the access completes (zero-wait) and the FSM stays in `IDLE`.
  - Otherwise `StallM=1`, the FSM moves to `WAIT`, and `wcnt<=1`.
- `WAIT`:
  - `dmem_req=1`. M-stage inputs are held stable by the stall.
  - On `dmem_ready=1`, the access completes and the FSM returns to `IDLE`.
  - Otherwise, if `wcnt==TIMEOUT`, the access aborts: the W register loads `BusErrW=1` and `RegWriteW=0`, `StallM=0`, and the FSM returns to `IDLE`.
  - Otherwise `wcnt<=wcnt+1` and `StallM=1`.
  - `dmem_ready` takes priority over timeout in the same cycle.
- `StallM = dmem_req & ~dmem_ready & ~timeout_now`.
- W register update each cycle:
  - When `StallM=1`: loads a bubble (all control bits 0, flags 0; data fields unchanged).
  - Otherwise: loads the M instruction with `ReadDataW` set to the extended load data (0 for non-loads).
- Load extension uses lane `ALUOutM[1:0]` (byte) or `ALUOutM[1]` (half); the selected field is sign- or zero-extended per `MemSignedM`. Word loads pass through unchanged.
- Store byte enables:
  - byte: `4'b0001 << a[1:0]`.
  - half: `4'b0011 << {a[1],1'b0}`.
  - word: `4'b1111`.
- Store data lanes: byte → `{4{wd[7:0]}}`, half → `{2{wd[15:0]}}`, word → `wd`.
- `dmem_we`, `dmem_be`, and `dmem_wdata` are don't-care when `dmem_req=0`; they are driven to 0.

## Timing
- Reset (async assert, sync release): FSM to `IDLE`, `wcnt=0`, all W outputs 0. `dmem_req` and `StallM` are low whenever `rst_n=0`.
- Latency: a zero-wait access is visible on the W outputs on the next edge. An access completing on wait cycle N is visible N+1 edges after issue.
- Bus contract: `dmem_req`, `dmem_addr`, `dmem_be`, `dmem_we`, and `dmem_wdata` stay stable from issue until the cycle `dmem_ready` is sampled high. `dmem_ready` without `dmem_req` is ignored.
- Timeout abort: occurs at wait cycle `TIMEOUT`, so the stall lasts exactly `TIMEOUT` cycles.
- Reset during `WAIT` abandons the access. No partial W write occurs.

## Structure
- A shared package holds the `MemSizeM` encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`) and the FSM state encoding.
- Sub-module `load_align_ext` is combinational: `rdata`, addr[1:0], size, signed → 32-bit extended result. It is reused by any future uncached load path.
- The FSM, counter, store lane logic, and W register live in the top module.

## Test plan
- Zero-wait `lw` at 0x100, `dmem_rdata=0xDEADBEEF` with `dmem_ready` in the issue cycle → no stall; next edge `ReadDataW=0xDEADBEEF`, `MemtoRegW=1`, `RegWriteW=1`.
- `lb` signed at 0x103, `rdata=0x80xxxxxx`, ready after 3 waits → `StallM` high for 3 cycles with bubbles in W; then `ReadDataW=0xFFFFFF80`. Repeat as `lbu` → `0x00000080`.
- `sh` at 0x102, `WriteDataM=0x1234ABCD` → `dmem_be=4'b1100`, `dmem_wdata=0xABCDABCD`, `dmem_we=1`.
- `lw` at 0x101 → no `dmem_req`, no stall; next cycle `AlignErrW=1`, `RegWriteW=0`.
- With `TIMEOUT=4` and `dmem_ready` never asserted → 4 stall cycles, then `BusErrW=1` and `RegWriteW=0`. With ready arriving on wait cycle 4, the access completes normally and `BusErrW=0`.
- Assert `rst_n=0` mid-`WAIT` → `dmem_req`, `StallM`, and all W outputs drop to 0 immediately. After release, a new `lw` issues cleanly.
